// File: rtl/l2_ddr_port.sv
`default_nettype none
// ============================================================================
// Module   : l2_ddr_port
// Purpose  : Burst bridge between the L2 cache and the DDR application
//            interface. L2 requests a burst of BURST_WORDS 128-bit words;
//            reads walk upward from the base pointer, writes walk the
//            BURST_WORDS words just below it. The base pointer is moved by
//            completed bursts, single-word inc/dec steps and jump loads.
// Ports    : clk_166M66, mcu_sys_rst_n (async, active-low)
//            L2 side : i_l2_req, i_l2_rw, o_l2_bus_enable, o_l2_lock,
//                      o_l2_force_loading, i_base_inc, i_base_dec, i_jump,
//                      i_jump_addr, o_l2_rd_data, o_l2_rd_valid,
//                      i_l2_wr_data, o_l2_wr_take
//            DDR side: i_calib_done, o_app_cmd_valid, o_app_cmd_rw,
//                      o_app_addr, i_app_cmd_ready, i_app_rd_data,
//                      i_app_rd_valid, o_app_wr_data, o_app_wr_valid,
//                      i_app_wr_ready
// Revision : 1.0 - initial release
// ============================================================================
module l2_ddr_port #(
    parameter int BURST_WORDS = 8,
    parameter int ADDR_W      = 24
) (
    input  logic              clk_166M66,
    input  logic              mcu_sys_rst_n,
    input  logic              i_l2_req,
    input  logic              i_l2_rw,
    output logic              o_l2_bus_enable,
    output logic              o_l2_lock,
    output logic              o_l2_force_loading,
    input  logic              i_base_inc,
    input  logic              i_base_dec,
    input  logic              i_jump,
    input  logic [ADDR_W-1:0] i_jump_addr,
    output logic [127:0]      o_l2_rd_data,
    output logic              o_l2_rd_valid,
    input  logic [127:0]      i_l2_wr_data,
    output logic              o_l2_wr_take,
    input  logic              i_calib_done,
    output logic              o_app_cmd_valid,
    output logic              o_app_cmd_rw,
    output logic [ADDR_W-1:0] o_app_addr,
    input  logic              i_app_cmd_ready,
    input  logic [127:0]      i_app_rd_data,
    input  logic              i_app_rd_valid,
    output logic [127:0]      o_app_wr_data,
    output logic              o_app_wr_valid,
    input  logic              i_app_wr_ready
);

    localparam int                 c_cnt_w     = $clog2(BURST_WORDS) + 1;
    localparam logic [c_cnt_w-1:0] c_burst_cnt = c_cnt_w'(BURST_WORDS);
    localparam logic [c_cnt_w-1:0] c_last_cnt  = c_cnt_w'(BURST_WORDS - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
    localparam logic [ADDR_W-1:0]  c_burst_adr = ADDR_W'(BURST_WORDS);
    localparam logic [ADDR_W-1:0]  c_addr_one  = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GRANT    = 3'd1,
        S_RD_BURST = 3'd2,
        S_WR_BURST = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_base;
    logic [ADDR_W-1:0]   r_addr;
    logic [c_cnt_w-1:0]  r_cmd_cnt;
    logic [c_cnt_w-1:0]  r_dat_cnt;
    logic                r_rw;
    logic                r_bus_en;
    logic                r_jump_pend;
    logic                r_force;
    logic                r_out_of_rst;
    logic                r_rd_valid;
    logic [127:0]        r_rd_data;

    logic                w_start;
    logic                w_cmd_fire;
    logic                w_rd_fire;
    logic                w_wr_fire;
    logic [ADDR_W-1:0]   w_base_step;
    logic [ADDR_W-1:0]   w_burst_adj;

    assign w_start    = (r_state == S_IDLE) && i_l2_req && i_calib_done && !i_jump;
    assign w_cmd_fire = (r_state == S_RD_BURST) && (r_cmd_cnt != c_burst_cnt) && i_app_cmd_ready;
    // Read data is only accepted inside a read burst, so words still in
    // flight from a burst killed by reset are dropped in IDLE.
    assign w_rd_fire  = (r_state == S_RD_BURST) && i_app_rd_valid;
    assign w_wr_fire  = (r_state == S_WR_BURST) && i_app_cmd_ready && i_app_wr_ready;

    // ------------------------------------------------------------------
    // Burst sequencer. The start address is captured from the base on
    // IDLE exit and pulled down by one burst in GRANT if it turns out to
    // be a write, so the direction is taken from i_l2_rw in GRANT.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_166M66 or negedge mcu_sys_rst_n) begin
        if (!mcu_sys_rst_n) begin
            r_state   <= S_IDLE;
            r_bus_en  <= 1'b0;
            r_rw      <= 1'b0;
            r_addr    <= '0;
            r_cmd_cnt <= '0;
            r_dat_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state  <= S_GRANT;
                        r_bus_en <= 1'b1;
                        r_addr   <= r_base;
                    end
                end
                S_GRANT: begin
                    r_rw      <= i_l2_rw;
                    r_cmd_cnt <= '0;
                    r_dat_cnt <= '0;
                    if (i_l2_rw) begin
                        r_state <= S_WR_BURST;
                        r_addr  <= r_addr - c_burst_adr;
                    end else begin
                        r_state <= S_RD_BURST;
                    end
                end
                S_RD_BURST: begin
                    if (w_cmd_fire) begin
                        r_cmd_cnt <= r_cmd_cnt + c_cnt_one;
                        r_addr    <= r_addr + c_addr_one;
                    end
                    if (w_rd_fire) begin
                        r_dat_cnt <= r_dat_cnt + c_cnt_one;
                        if (r_dat_cnt == c_last_cnt) begin
                            r_state  <= S_DONE;
                            r_bus_en <= 1'b0;
                        end
                    end
                end
                S_WR_BURST: begin
                    if (w_wr_fire) begin
                        r_cmd_cnt <= r_cmd_cnt + c_cnt_one;
                        r_dat_cnt <= r_dat_cnt + c_cnt_one;
                        r_addr    <= r_addr + c_addr_one;
                        if (r_dat_cnt == c_last_cnt) begin
                            r_state  <= S_DONE;
                            r_bus_en <= 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_bus_en <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Base pointer: single-word steps and the end-of-burst update sum;
    // a jump overrides both. A jump seen during a burst cancels that
    // burst's end-of-burst update.
    // ------------------------------------------------------------------
    always_comb begin
        w_base_step = '0;
        if (i_base_inc && !i_base_dec) begin
            w_base_step = c_addr_one;
        end else if (i_base_dec && !i_base_inc) begin
            w_base_step = '1;
        end
        w_burst_adj = '0;
        if ((r_state == S_DONE) && !r_jump_pend) begin
            w_burst_adj = r_rw ? (~c_burst_adr + c_addr_one) : c_burst_adr;
        end
    end

    always_ff @(posedge clk_166M66 or negedge mcu_sys_rst_n) begin
        if (!mcu_sys_rst_n) begin
            r_base       <= '0;
            r_jump_pend  <= 1'b0;
            r_force      <= 1'b0;
            r_out_of_rst <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_rd_data    <= '0;
        end else begin
            if (i_jump) begin
                r_base <= i_jump_addr;
            end else begin
                r_base <= r_base + w_base_step + w_burst_adj;
            end
            if (r_state == S_IDLE) begin
                r_jump_pend <= 1'b0;
            end else if (i_jump) begin
                r_jump_pend <= 1'b1;
            end
            r_force      <= i_jump;
            // Holds lock high until the first edge after reset release.
            r_out_of_rst <= 1'b1;
            r_rd_valid   <= w_rd_fire;
            if (w_rd_fire) begin
                r_rd_data <= i_app_rd_data;
            end
        end
    end

    assign o_l2_bus_enable    = r_bus_en;
    assign o_l2_force_loading = r_force;
    assign o_l2_lock          = !r_out_of_rst || !i_calib_done || (r_state != S_IDLE);
    assign o_l2_rd_valid      = r_rd_valid;
    assign o_l2_rd_data       = r_rd_data;
    assign o_l2_wr_take       = w_wr_fire;

    assign o_app_cmd_valid = ((r_state == S_RD_BURST) && (r_cmd_cnt != c_burst_cnt))
                           || (r_state == S_WR_BURST);
    assign o_app_cmd_rw    = (r_state == S_WR_BURST);
    assign o_app_addr      = r_addr;
    assign o_app_wr_valid  = (r_state == S_WR_BURST);
    assign o_app_wr_data   = (r_state == S_WR_BURST) ? i_l2_wr_data : '0;

endmodule
`default_nettype wire

// File: tb/tb_l2_ddr_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_l2_ddr_port
// Purpose  : Directed self-checking bench for l2_ddr_port with a small DDR
//            responder (fixed 3-cycle read latency) and a bus monitor.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_l2_ddr_port;

    localparam logic [103:0] RD_TAG = 104'hA5A5;
    localparam logic [127:0] WBASE  = 128'hFEED_0000;

    logic          clk_166M66 = 1'b0;
    logic          mcu_sys_rst_n;
    logic          i_l2_req, i_l2_rw, i_base_inc, i_base_dec, i_jump;
    logic [23:0]   i_jump_addr;
    logic [127:0]  i_l2_wr_data, i_app_rd_data;
    logic          i_calib_done, i_app_cmd_ready, i_app_rd_valid, i_app_wr_ready;
    logic          o_l2_bus_enable, o_l2_lock, o_l2_force_loading, o_l2_rd_valid, o_l2_wr_take;
    logic [127:0]  o_l2_rd_data, o_app_wr_data;
    logic          o_app_cmd_valid, o_app_cmd_rw, o_app_wr_valid;
    logic [23:0]   o_app_addr;

    l2_ddr_port #(.BURST_WORDS(8), .ADDR_W(24)) dut (
        .clk_166M66         (clk_166M66),
        .mcu_sys_rst_n      (mcu_sys_rst_n),
        .i_l2_req           (i_l2_req),
        .i_l2_rw            (i_l2_rw),
        .o_l2_bus_enable    (o_l2_bus_enable),
        .o_l2_lock          (o_l2_lock),
        .o_l2_force_loading (o_l2_force_loading),
        .i_base_inc         (i_base_inc),
        .i_base_dec         (i_base_dec),
        .i_jump             (i_jump),
        .i_jump_addr        (i_jump_addr),
        .o_l2_rd_data       (o_l2_rd_data),
        .o_l2_rd_valid      (o_l2_rd_valid),
        .i_l2_wr_data       (i_l2_wr_data),
        .o_l2_wr_take       (o_l2_wr_take),
        .i_calib_done       (i_calib_done),
        .o_app_cmd_valid    (o_app_cmd_valid),
        .o_app_cmd_rw       (o_app_cmd_rw),
        .o_app_addr         (o_app_addr),
        .i_app_cmd_ready    (i_app_cmd_ready),
        .i_app_rd_data      (i_app_rd_data),
        .i_app_rd_valid     (i_app_rd_valid),
        .o_app_wr_data      (o_app_wr_data),
        .o_app_wr_valid     (o_app_wr_valid),
        .i_app_wr_ready     (i_app_wr_ready)
    );

    always #5 clk_166M66 = ~clk_166M66;

    int n_checks = 0;
    int n_pass   = 0;

    logic [23:0]  rd_cmd_addrs[$];
    logic [23:0]  wr_addrs[$];
    logic [127:0] wr_datas[$];
    logic [127:0] rd_words[$];
    logic         rd_busen[$];
    int           force_cnt, lat_err, proto_err;
    logic         lat_chk, wr_toggle, take_seen, prev_v;
    logic [127:0] prev_d;
    logic         pipe_v[3];
    logic [127:0] pipe_d[3];

    // Inputs change on the falling edge; handshakes are sampled 3 ns later,
    // i.e. 2 ns before the rising edge that acts on them.
    always @(negedge clk_166M66) begin
        i_app_rd_valid = pipe_v[2];
        i_app_rd_data  = pipe_d[2];
        pipe_v[2] = pipe_v[1]; pipe_d[2] = pipe_d[1];
        pipe_v[1] = pipe_v[0]; pipe_d[1] = pipe_d[0];
        pipe_v[0] = 1'b0;      pipe_d[0] = '0;
        if (wr_toggle) i_app_wr_ready = ~i_app_wr_ready;
        if (take_seen) i_l2_wr_data = i_l2_wr_data + 128'd1;
        take_seen = 1'b0;
        #3;
        if (o_app_cmd_valid && i_app_cmd_ready && !o_app_cmd_rw) begin
            rd_cmd_addrs.push_back(o_app_addr);
            pipe_v[0] = 1'b1;
            pipe_d[0] = {RD_TAG, o_app_addr};
        end
        if (o_l2_wr_take) begin
            wr_addrs.push_back(o_app_addr);
            wr_datas.push_back(o_app_wr_data);
            take_seen = 1'b1;
        end
        if (o_l2_wr_take !== (o_app_wr_valid && i_app_cmd_ready && i_app_wr_ready)) proto_err++;
        if (o_app_wr_valid && (!o_app_cmd_valid || !o_app_cmd_rw || o_app_wr_data !== i_l2_wr_data)) proto_err++;
        if (o_l2_rd_valid) begin
            rd_words.push_back(o_l2_rd_data);
            rd_busen.push_back(o_l2_bus_enable);
        end
        if (lat_chk && (o_l2_rd_valid !== prev_v || (prev_v && o_l2_rd_data !== prev_d))) lat_err++;
        prev_v = i_app_rd_valid;
        prev_d = i_app_rd_data;
        if (o_l2_force_loading) force_cnt++;
    end

    task automatic clear_mon();
        rd_cmd_addrs.delete(); wr_addrs.delete(); wr_datas.delete();
        rd_words.delete(); rd_busen.delete();
        force_cnt = 0; lat_err = 0; proto_err = 0;
    endtask

    task automatic set_base(input logic [23:0] a);
        force_cnt = 0;
        @(negedge clk_166M66); i_jump = 1'b1; i_jump_addr = a;
        @(negedge clk_166M66); i_jump = 1'b0;
        repeat (2) @(negedge clk_166M66);
    endtask

    // Requests one burst, drops req once granted, optionally pulses a jump
    // jump_at cycles after the grant, and waits for the grant to end.
    task automatic do_burst(input logic rw, input int jump_at, input logic [23:0] jaddr);
        int t;
        @(negedge clk_166M66); i_l2_req = 1'b1; i_l2_rw = rw;
        t = 0;
        do begin @(negedge clk_166M66); t++; end while (!o_l2_bus_enable && t < 20);
        i_l2_req = 1'b0;
        t = 0;
        while (o_l2_bus_enable && t < 300) begin
            @(negedge clk_166M66); t++;
            i_jump = (jump_at != 0 && t == jump_at);
            i_jump_addr = jaddr;
        end
        i_jump = 1'b0;
        n_checks++;
        if (t >= 300) $display("FAIL burst_timeout: bus_enable still %b after %0d cycles, required 0", o_l2_bus_enable, t);
        else n_pass++;
        repeat (6) @(negedge clk_166M66);
    endtask

    task automatic test_reset();
        #1 mcu_sys_rst_n = 1'b0;
        #1;
        n_checks++; if (o_l2_lock !== 1'b1) $display("FAIL rst_lock: got %b required 1", o_l2_lock); else n_pass++;
        n_checks++; if (o_l2_bus_enable !== 1'b0) $display("FAIL rst_bus_enable: got %b required 0", o_l2_bus_enable); else n_pass++;
        n_checks++; if (o_app_cmd_valid !== 1'b0) $display("FAIL rst_cmd_valid: got %b required 0", o_app_cmd_valid); else n_pass++;
        n_checks++; if (o_l2_rd_valid !== 1'b0) $display("FAIL rst_rd_valid: got %b required 0", o_l2_rd_valid); else n_pass++;
        repeat (2) @(negedge clk_166M66);
        mcu_sys_rst_n = 1'b1;
        @(negedge clk_166M66);
        n_checks++; if (o_l2_lock !== 1'b0) $display("FAIL lock_after_rst: got %b required 0", o_l2_lock); else n_pass++;
        // Not calibrated: lock held and requests ignored.
        i_calib_done = 1'b0; i_l2_req = 1'b1;
        repeat (3) @(negedge clk_166M66);
        n_checks++; if (o_l2_lock !== 1'b1) $display("FAIL lock_uncal: got %b required 1", o_l2_lock); else n_pass++;
        n_checks++; if (o_l2_bus_enable !== 1'b0) $display("FAIL grant_uncal: got %b required 0", o_l2_bus_enable); else n_pass++;
        i_l2_req = 1'b0; i_calib_done = 1'b1;
        @(negedge clk_166M66);
    endtask

    task automatic test_read_burst();
        set_base(24'h000100);
        n_checks++; if (force_cnt !== 1) $display("FAIL force_pulse_idle: got %0d pulses required 1", force_cnt); else n_pass++;
        clear_mon(); lat_chk = 1'b1;
        do_burst(1'b0, 0, 24'h0);
        n_checks++; if (rd_cmd_addrs.size() !== 8) $display("FAIL rd_cmd_count: got %0d required 8", rd_cmd_addrs.size()); else n_pass++;
        for (int k = 0; k < rd_cmd_addrs.size(); k++) begin
            n_checks++;
            if (rd_cmd_addrs[k] !== 24'(24'h000100 + k)) $display("FAIL rd_addr[%0d]: got %h required %h", k, rd_cmd_addrs[k], 24'(24'h000100 + k));
            else n_pass++;
        end
        n_checks++; if (rd_words.size() !== 8) $display("FAIL rd_word_count: got %0d required 8", rd_words.size()); else n_pass++;
        for (int k = 0; k < rd_words.size(); k++) begin
            n_checks++;
            if (rd_words[k] !== {RD_TAG, 24'(24'h000100 + k)}) $display("FAIL rd_data[%0d]: got %h required %h", k, rd_words[k], {RD_TAG, 24'(24'h000100 + k)});
            else n_pass++;
        end
        if (rd_busen.size() == 8) begin
            n_checks++; if (rd_busen[6] !== 1'b1) $display("FAIL bus_en_word7: got %b required 1", rd_busen[6]); else n_pass++;
            n_checks++; if (rd_busen[7] !== 1'b0) $display("FAIL bus_en_word8: got %b required 0", rd_busen[7]); else n_pass++;
        end
        n_checks++; if (lat_err !== 0) $display("FAIL rd_latency: got %0d bad cycles required 0", lat_err); else n_pass++;
    endtask

    task automatic test_write_backpressure();
        clear_mon();
        i_l2_wr_data = WBASE; i_app_wr_ready = 1'b0; wr_toggle = 1'b1;
        do_burst(1'b1, 0, 24'h0);
        wr_toggle = 1'b0;
        @(negedge clk_166M66); i_app_wr_ready = 1'b1;
        n_checks++; if (wr_addrs.size() !== 8) $display("FAIL wr_take_count: got %0d required 8", wr_addrs.size()); else n_pass++;
        for (int k = 0; k < wr_addrs.size(); k++) begin
            n_checks++;
            if (wr_addrs[k] !== 24'(24'h000100 + k) || wr_datas[k] !== WBASE + 128'(k))
                $display("FAIL wr_word[%0d]: got addr %h data %h required addr %h data %h", k, wr_addrs[k], wr_datas[k], 24'(24'h000100 + k), WBASE + 128'(k));
            else n_pass++;
        end
        n_checks++; if (proto_err !== 0) $display("FAIL wr_handshake: got %0d bad cycles required 0", proto_err); else n_pass++;
        n_checks++; if (rd_cmd_addrs.size() !== 0) $display("FAIL wr_no_rd_cmd: got %0d required 0", rd_cmd_addrs.size()); else n_pass++;
        clear_mon();
        do_burst(1'b0, 0, 24'h0);
        n_checks++;
        if (rd_cmd_addrs.size() == 0 || rd_cmd_addrs[0] !== 24'h000100) $display("FAIL base_after_write: got %h required 000100", rd_cmd_addrs.size() ? rd_cmd_addrs[0] : 24'hxxxxxx);
        else n_pass++;
    endtask

    task automatic test_wrap();
        set_base(24'hFFFFFC);
        clear_mon();
        do_burst(1'b0, 0, 24'h0);
        n_checks++; if (rd_cmd_addrs.size() !== 8) $display("FAIL wrap_cmd_count: got %0d required 8", rd_cmd_addrs.size()); else n_pass++;
        for (int k = 0; k < rd_cmd_addrs.size(); k++) begin
            n_checks++;
            if (rd_cmd_addrs[k] !== 24'(24'hFFFFFC + k)) $display("FAIL wrap_addr[%0d]: got %h required %h", k, rd_cmd_addrs[k], 24'(24'hFFFFFC + k));
            else n_pass++;
        end
    endtask

    task automatic test_inc_dec();
        // Base is 0x000004 after the wrapping burst.
        @(negedge clk_166M66); i_base_inc = 1'b1; i_base_dec = 1'b1;
        repeat (5) @(negedge clk_166M66);
        i_base_inc = 1'b0; i_base_dec = 1'b0;
        clear_mon();
        do_burst(1'b0, 0, 24'h0);
        n_checks++;
        if (rd_cmd_addrs.size() == 0 || rd_cmd_addrs[0] !== 24'h000004) $display("FAIL inc_dec_both: got %h required 000004", rd_cmd_addrs.size() ? rd_cmd_addrs[0] : 24'hxxxxxx);
        else n_pass++;
        i_base_inc = 1'b1;
        repeat (3) @(negedge clk_166M66);
        i_base_inc = 1'b0;
        clear_mon();
        do_burst(1'b0, 0, 24'h0);
        n_checks++;
        if (rd_cmd_addrs.size() == 0 || rd_cmd_addrs[0] !== 24'h00000F) $display("FAIL inc_three: got %h required 00000F", rd_cmd_addrs.size() ? rd_cmd_addrs[0] : 24'hxxxxxx);
        else n_pass++;
    endtask

    task automatic test_jump_mid_burst();
        set_base(24'h000040);
        clear_mon();
        do_burst(1'b0, 3, 24'h002000);
        n_checks++; if (rd_words.size() !== 8) $display("FAIL jump_rd_words: got %0d required 8", rd_words.size()); else n_pass++;
        for (int k = 0; k < rd_cmd_addrs.size(); k++) begin
            n_checks++;
            if (rd_cmd_addrs[k] !== 24'(24'h000040 + k)) $display("FAIL jump_addr[%0d]: got %h required %h", k, rd_cmd_addrs[k], 24'(24'h000040 + k));
            else n_pass++;
        end
        n_checks++; if (force_cnt !== 1) $display("FAIL jump_force_pulse: got %0d pulses required 1", force_cnt); else n_pass++;
        clear_mon();
        do_burst(1'b0, 0, 24'h0);
        n_checks++;
        if (rd_cmd_addrs.size() == 0 || rd_cmd_addrs[0] !== 24'h002000) $display("FAIL base_after_jump: got %h required 002000", rd_cmd_addrs.size() ? rd_cmd_addrs[0] : 24'hxxxxxx);
        else n_pass++;
    endtask

    task automatic test_reset_mid_burst();
        int t;
        clear_mon(); lat_chk = 1'b0;
        @(negedge clk_166M66); i_l2_req = 1'b1; i_l2_rw = 1'b0;
        t = 0;
        while (rd_cmd_addrs.size() < 3 && t < 50) begin @(negedge clk_166M66); #4; t++; end
        n_checks++; if (t >= 50) $display("FAIL rst_burst_start: got %0d commands required 3", rd_cmd_addrs.size()); else n_pass++;
        #2 mcu_sys_rst_n = 1'b0; i_l2_req = 1'b0;
        #1;
        n_checks++; if (o_l2_lock !== 1'b1) $display("FAIL mid_rst_lock: got %b required 1", o_l2_lock); else n_pass++;
        n_checks++; if (o_l2_bus_enable !== 1'b0) $display("FAIL mid_rst_bus_enable: got %b required 0", o_l2_bus_enable); else n_pass++;
        n_checks++; if (o_app_cmd_valid !== 1'b0) $display("FAIL mid_rst_cmd_valid: got %b required 0", o_app_cmd_valid); else n_pass++;
        n_checks++; if (o_app_addr !== 24'h0) $display("FAIL mid_rst_addr: got %h required 000000", o_app_addr); else n_pass++;
        @(negedge clk_166M66); mcu_sys_rst_n = 1'b1;
        repeat (8) @(negedge clk_166M66);
        n_checks++; if (rd_words.size() !== 0) $display("FAIL late_rd_valid: got %0d words required 0", rd_words.size()); else n_pass++;
        clear_mon(); lat_chk = 1'b1;
        do_burst(1'b0, 0, 24'h0);
        n_checks++;
        if (rd_cmd_addrs.size() == 0 || rd_cmd_addrs[0] !== 24'h000000) $display("FAIL base_after_rst: got %h required 000000", rd_cmd_addrs.size() ? rd_cmd_addrs[0] : 24'hxxxxxx);
        else n_pass++;
        n_checks++; if (rd_words.size() !== 8) $display("FAIL rd_after_rst: got %0d words required 8", rd_words.size()); else n_pass++;
    endtask

    initial begin
        mcu_sys_rst_n = 1'b1;
        i_l2_req = 1'b0; i_l2_rw = 1'b0; i_base_inc = 1'b0; i_base_dec = 1'b0;
        i_jump = 1'b0; i_jump_addr = '0; i_l2_wr_data = '0; i_app_rd_data = '0;
        i_calib_done = 1'b1; i_app_cmd_ready = 1'b1; i_app_rd_valid = 1'b0; i_app_wr_ready = 1'b1;
        lat_chk = 1'b0; wr_toggle = 1'b0; take_seen = 1'b0; prev_v = 1'b0; prev_d = '0;
        for (int k = 0; k < 3; k++) begin pipe_v[k] = 1'b0; pipe_d[k] = '0; end
        clear_mon();
        test_reset();
        test_read_burst();
        test_write_backpressure();
        test_wrap();
        test_inc_dec();
        test_jump_mid_burst();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
